// File: rtl/npu_top.sv
// Memory-mapped int8 GEMM accelerator. The bus decodes into A/W/B/OS/ACT buffers, a parameter file
// and a command region, and one MAC per cycle walks an ARRAY_N x ARRAY_M output tile.
package pkg_memorymap;
  localparam logic [31:0] NPU_IMEM_Start = 32'h4000_0000;
  localparam logic [31:0] NPU_WMEM_Start = 32'h4001_0000;
  localparam logic [31:0] NPU_BMEM_Start = 32'h4002_0000;
  localparam logic [31:0] NPU_OMEM_Start = 32'h4003_0000;
  localparam logic [31:0] NPU_PARA_Start = 32'h4004_0000;
  localparam logic [31:0] NPU_OP_Start   = 32'h4005_0000;
endpackage

module npu_top
  import pkg_memorymap::*;
#(
  parameter int unsigned DWidth       = 32,
  parameter int unsigned ARRAY_N      = 16,
  parameter int unsigned ARRAY_M      = 16,
  parameter int unsigned ACT_WIDTH    = 8,
  parameter int unsigned WGT_WIDTH    = 8,
  parameter int unsigned PE_OUT_WIDTH = 32,
  parameter int unsigned RAM_SIZE     = 1024,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cen_i,
  input  logic                         wen_i,
  input  logic [DWidth-1:0]            addr_i,
  input  logic [DWidth-1:0]            wdata_i,
  output logic [DWidth-1:0]            rdata_o,
  output logic [DWidth-1:0]            debug1_o,
  output logic [DWidth-1:0]            debug2_o,
  output logic [3:0]                   debug3_o,
  output logic [ACT_WIDTH*ARRAY_N-1:0] debug_output
);

  localparam int unsigned IdxW  = $clog2(RAM_SIZE);
  localparam int unsigned RegW  = 16;
  localparam int unsigned TileN = ARRAY_N * ARRAY_M;
  localparam int unsigned ProdW = ACT_WIDTH + WGT_WIDTH;
  localparam int unsigned DbgW  = ACT_WIDTH * ARRAY_N;

  localparam logic [RegW-1:0] OffStatus = RegW'(32'h04);
  localparam logic [RegW-1:0] OffABase  = RegW'(32'h08);
  localparam logic [RegW-1:0] OffARows  = RegW'(32'h0C);
  localparam logic [RegW-1:0] OffWBase  = RegW'(32'h10);
  localparam logic [RegW-1:0] OffWCols  = RegW'(32'h14);
  localparam logic [RegW-1:0] OffOBase  = RegW'(32'h18);
  localparam logic [RegW-1:0] OffIntraO = RegW'(32'h1C);
  localparam logic [RegW-1:0] OffIntraA = RegW'(32'h20);
  localparam logic [RegW-1:0] OffKLast  = RegW'(32'h24);

  localparam logic signed [PE_OUT_WIDTH-1:0] SatHi  = PE_OUT_WIDTH'((1 << (ACT_WIDTH - 1)) - 1);
  localparam logic signed [PE_OUT_WIDTH-1:0] SatLo  = ~SatHi;
  localparam logic signed [ACT_WIDTH-1:0]    ActMin = ACT_WIDTH'(SatLo);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_MAC  = 4'd1,
    S_WB   = 4'd2,
    S_XFER = 4'd3
  } state_e;

  state_e state_q, state_d;

  logic signed [ACT_WIDTH-1:0]    a_mem   [RAM_SIZE];
  logic signed [WGT_WIDTH-1:0]    w_mem   [RAM_SIZE];
  logic signed [PE_OUT_WIDTH-1:0] b_mem   [RAM_SIZE];
  logic signed [PE_OUT_WIDTH-1:0] os_mem  [RAM_SIZE];
  logic signed [ACT_WIDTH-1:0]    act_mem [RAM_SIZE];

  logic [ADDR_WIDTH-1:0] a_base_q, a_rows_q, w_base_q, w_cols_q;
  logic [ADDR_WIDTH-1:0] o_base_q, intra_o_q, intra_a_q, k_last_q;
  logic [ADDR_WIDTH-1:0] r_q, c_q, k_q, i_q, r_nxt, c_nxt;
  logic signed [PE_OUT_WIDTH-1:0] acc_q;
  logic signed [ACT_WIDTH-1:0]    max_q;
  logic                  done_q;
  logic [DWidth-1:0]     busy_cnt_q, rdata_q;
  logic [DbgW-1:0]       dbg_out_q;

  // Bus decode: regions are 64 KiB aligned, buffer index wraps at RAM_SIZE words
  logic bus_wr, busy, hit_a, hit_w, hit_b, hit_o, hit_p, hit_op;
  logic start_gemm, start_xfer;
  logic [RegW-1:0] reg_off;
  logic [IdxW-1:0] bus_idx;

  assign bus_wr  = cen_i & wen_i;
  assign busy    = (state_q != S_IDLE);
  assign reg_off = addr_i[RegW-1:0];
  assign bus_idx = addr_i[IdxW+1:2];
  assign hit_a   = (addr_i[DWidth-1:RegW] == NPU_IMEM_Start[DWidth-1:RegW]);
  assign hit_w   = (addr_i[DWidth-1:RegW] == NPU_WMEM_Start[DWidth-1:RegW]);
  assign hit_b   = (addr_i[DWidth-1:RegW] == NPU_BMEM_Start[DWidth-1:RegW]);
  assign hit_o   = (addr_i[DWidth-1:RegW] == NPU_OMEM_Start[DWidth-1:RegW]);
  assign hit_p   = (addr_i[DWidth-1:RegW] == NPU_PARA_Start[DWidth-1:RegW]);
  assign hit_op  = (addr_i[DWidth-1:RegW] == NPU_OP_Start[DWidth-1:RegW]);

  assign start_gemm = bus_wr & hit_op & (reg_off == RegW'(0)) & wdata_i[0] & ~busy;
  assign start_xfer = bus_wr & hit_op & (reg_off == RegW'(4)) & wdata_i[0] & ~busy;

  // Engine addressing, all modulo RAM_SIZE
  logic [IdxW-1:0] a_idx, w_idx, o_idx, xs_idx, xd_idx, bias_idx;
  assign a_idx    = IdxW'(a_base_q) + IdxW'(r_q) * IdxW'(ARRAY_N) + IdxW'(k_q);
  assign w_idx    = IdxW'(w_base_q) + IdxW'(k_q) * IdxW'(ARRAY_M) + IdxW'(c_q);
  assign o_idx    = IdxW'(o_base_q) + IdxW'(intra_o_q) + IdxW'(r_q) * IdxW'(ARRAY_M) + IdxW'(c_q);
  assign xs_idx   = IdxW'(o_base_q) + IdxW'(intra_o_q) + IdxW'(i_q);
  assign xd_idx   = IdxW'(intra_a_q) + IdxW'(i_q);
  assign bias_idx = IdxW'(c_nxt);

  logic signed [ACT_WIDTH-1:0]    a_val, sat_val;
  logic signed [WGT_WIDTH-1:0]    w_val;
  logic signed [ProdW-1:0]        prod;
  logic signed [PE_OUT_WIDTH-1:0] prod_ext, os_val;

  assign a_val    = a_mem[a_idx];
  assign w_val    = w_mem[w_idx];
  assign prod     = a_val * w_val;
  assign prod_ext = PE_OUT_WIDTH'(prod);
  assign os_val   = os_mem[xs_idx];

  always_comb begin
    sat_val = os_val[ACT_WIDTH-1:0];
    if (os_val > SatHi)      sat_val = ACT_WIDTH'(SatHi);
    else if (os_val < SatLo) sat_val = ActMin;
  end

  logic k_done, c_last, r_last, x_last, dims_zero;
  assign k_done    = (k_q == k_last_q);
  assign c_last    = (c_q == w_cols_q - ADDR_WIDTH'(1));
  assign r_last    = (r_q == a_rows_q - ADDR_WIDTH'(1));
  assign x_last    = (i_q == ADDR_WIDTH'(TileN - 1));
  assign dims_zero = (a_rows_q == '0) || (w_cols_q == '0);
  assign c_nxt     = c_last ? '0 : c_q + ADDR_WIDTH'(1);
  assign r_nxt     = c_last ? r_q + ADDR_WIDTH'(1) : r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_gemm && !dims_zero) state_d = S_MAC;
        else if (start_xfer)          state_d = S_XFER;
      end
      S_MAC:   if (k_done) state_d = S_WB;
      S_WB:    state_d = (c_last && r_last) ? S_IDLE : S_MAC;
      S_XFER:  if (x_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Parameters, engine counters, accumulator and status
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_base_q   <= '0;
      a_rows_q   <= '0;
      w_base_q   <= '0;
      w_cols_q   <= '0;
      o_base_q   <= '0;
      intra_o_q  <= '0;
      intra_a_q  <= '0;
      k_last_q   <= '0;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      i_q        <= '0;
      acc_q      <= '0;
      max_q      <= '0;
      done_q     <= 1'b0;
      busy_cnt_q <= '0;
      dbg_out_q  <= '0;
    end else begin
      if (bus_wr && hit_p && !busy) begin
        unique case (reg_off)
          OffABase:  a_base_q  <= wdata_i;
          OffARows:  a_rows_q  <= (wdata_i > DWidth'(ARRAY_N)) ? ADDR_WIDTH'(ARRAY_N) : wdata_i;
          OffWBase:  w_base_q  <= wdata_i;
          OffWCols:  w_cols_q  <= (wdata_i > DWidth'(ARRAY_M)) ? ADDR_WIDTH'(ARRAY_M) : wdata_i;
          OffOBase:  o_base_q  <= wdata_i;
          OffIntraO: intra_o_q <= wdata_i;
          OffIntraA: intra_a_q <= wdata_i;
          OffKLast:  k_last_q  <= wdata_i;
          default: ;
        endcase
      end

      if (start_gemm || start_xfer) busy_cnt_q <= '0;
      else if (busy)                busy_cnt_q <= busy_cnt_q + DWidth'(1);

      unique case (state_q)
        S_IDLE: begin
          if (start_gemm) begin
            r_q    <= '0;
            c_q    <= '0;
            k_q    <= '0;
            acc_q  <= b_mem[0];
            done_q <= dims_zero;
          end else if (start_xfer) begin
            i_q    <= '0;
            max_q  <= ActMin;
            done_q <= 1'b0;
          end
        end
        S_MAC: begin
          acc_q <= acc_q + prod_ext;
          k_q   <= k_done ? '0 : k_q + ADDR_WIDTH'(1);
        end
        S_WB: begin
          acc_q <= b_mem[bias_idx];
          c_q   <= c_nxt;
          r_q   <= r_nxt;
          if (c_last && r_last) done_q <= 1'b1;
        end
        S_XFER: begin
          if (sat_val > max_q) max_q <= sat_val;
          dbg_out_q <= {sat_val, dbg_out_q[DbgW-1:ACT_WIDTH]};
          i_q       <= i_q + ADDR_WIDTH'(1);
          if (x_last) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Buffers hold no reset; input buffers are frozen while the engine runs
  always_ff @(posedge clk_i) begin
    if (bus_wr && !busy) begin
      if (hit_a) a_mem[bus_idx] <= wdata_i[ACT_WIDTH-1:0];
      if (hit_w) w_mem[bus_idx] <= wdata_i[WGT_WIDTH-1:0];
      if (hit_b) b_mem[bus_idx] <= wdata_i[PE_OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_WB)   os_mem[o_idx]   <= acc_q;
    if (state_q == S_XFER) act_mem[xd_idx] <= sat_val;
  end

  // Read mux, sign-extended to the bus width
  logic signed [ACT_WIDTH-1:0]    rd_a, rd_act;
  logic signed [WGT_WIDTH-1:0]    rd_w;
  logic signed [PE_OUT_WIDTH-1:0] rd_b;
  logic [DWidth-1:0]              rd_val;

  assign rd_a   = a_mem[bus_idx];
  assign rd_w   = w_mem[bus_idx];
  assign rd_b   = b_mem[bus_idx];
  assign rd_act = act_mem[bus_idx];

  always_comb begin
    rd_val = '0;
    if (hit_a)      rd_val = DWidth'(rd_a);
    else if (hit_w) rd_val = DWidth'(rd_w);
    else if (hit_b) rd_val = DWidth'(rd_b);
    else if (hit_o) rd_val = (bus_idx == '0) ? DWidth'(max_q) : DWidth'(rd_act);
    else if (hit_p) begin
      unique case (reg_off)
        OffStatus: rd_val = DWidth'(done_q);
        OffABase:  rd_val = a_base_q;
        OffARows:  rd_val = a_rows_q;
        OffWBase:  rd_val = w_base_q;
        OffWCols:  rd_val = w_cols_q;
        OffOBase:  rd_val = o_base_q;
        OffIntraO: rd_val = intra_o_q;
        OffIntraA: rd_val = intra_a_q;
        OffKLast:  rd_val = k_last_q;
        default:   rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    rdata_q <= '0;
    else if (cen_i) rdata_q <= rd_val;
  end

  assign rdata_o      = rdata_q;
  assign debug1_o     = acc_q;
  assign debug2_o     = busy_cnt_q;
  assign debug3_o     = state_q;
  assign debug_output = dbg_out_q;

endmodule

// File: tb/tb_npu_top.sv
// Directed bench for npu_top: reset, parameters, GEMM, transfer/saturation, busy start and mid-run reset.
module tb_npu_top;
  import pkg_memorymap::*;

  localparam logic [31:0] P_STATUS = 32'h04;
  localparam logic [31:0] P_ABASE  = 32'h08;
  localparam logic [31:0] P_AROWS  = 32'h0C;
  localparam logic [31:0] P_WBASE  = 32'h10;
  localparam logic [31:0] P_WCOLS  = 32'h14;
  localparam logic [31:0] P_OBASE  = 32'h18;
  localparam logic [31:0] P_IOB    = 32'h1C;
  localparam logic [31:0] P_IAB    = 32'h20;
  localparam logic [31:0] P_KLAST  = 32'h24;

  logic         clk_i = 1'b0;
  logic         rst_ni, cen_i, wen_i;
  logic [31:0]  addr_i, wdata_i, rdata_o, debug1_o, debug2_o;
  logic [3:0]   debug3_o;
  logic [127:0] debug_output;

  int n_checks = 0;
  int n_fail   = 0;

  npu_top dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cen_i(cen_i), .wen_i(wen_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .debug1_o(debug1_o), .debug2_o(debug2_o), .debug3_o(debug3_o),
    .debug_output(debug_output)
  );

  always #5 clk_i = ~clk_i;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk_i);
    addr_i = a; wdata_i = d; cen_i = 1'b1; wen_i = 1'b1;
    @(posedge clk_i); #1;
    cen_i = 1'b0; wen_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk_i);
    addr_i = a; cen_i = 1'b1; wen_i = 1'b0;
    @(posedge clk_i); #1;
    d = rdata_o;
    cen_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    logic [31:0] v;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      bus_read(NPU_PARA_Start + P_STATUS, v);
      if (v[0]) ok = 1'b1;
    end
  endtask

  task automatic set_params(input int rows, input int cols, input int klast);
    bus_write(NPU_PARA_Start + P_ABASE, 32'd0);
    bus_write(NPU_PARA_Start + P_WBASE, 32'd0);
    bus_write(NPU_PARA_Start + P_OBASE, 32'd0);
    bus_write(NPU_PARA_Start + P_IOB,   32'd0);
    bus_write(NPU_PARA_Start + P_IAB,   32'd0);
    bus_write(NPU_PARA_Start + P_AROWS, 32'(rows));
    bus_write(NPU_PARA_Start + P_WCOLS, 32'(cols));
    bus_write(NPU_PARA_Start + P_KLAST, 32'(klast));
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst_ni = 1'b1; cen_i = 1'b0; wen_i = 1'b0; addr_i = '0; wdata_i = '0;
    #1 rst_ni = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
    n_checks++; if (rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
    n_checks++; if (debug3_o !== 4'h0) begin n_fail++; $display("FAIL reset_state: got %h expected 0", debug3_o); end
    n_checks++; if (debug_output !== 128'h0) begin n_fail++; $display("FAIL reset_dbgout: got %h expected 0", debug_output); end
    @(negedge clk_i) rst_ni = 1'b1;
    bus_read(NPU_PARA_Start + P_STATUS, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected 0", v); end
  endtask

  task automatic init_buffers;
    bit ok;
    for (int i = 0; i < 256; i++) bus_write(NPU_IMEM_Start + 32'(4 * i), 32'h0);
    for (int i = 0; i < 256; i++) bus_write(NPU_WMEM_Start + 32'(4 * i), 32'h0);
    for (int i = 0; i < 16; i++)  bus_write(NPU_BMEM_Start + 32'(4 * i), 32'h0);
    set_params(16, 16, 0);
    bus_write(NPU_OP_Start, 32'h1);
    wait_done(16 * 16 * 2 + 4, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL init_gemm_done: got %0b expected 1", ok); end
  endtask

  task automatic test_params;
    logic [31:0] v;
    bus_write(NPU_PARA_Start + P_AROWS, 32'd20);
    bus_read(NPU_PARA_Start + P_AROWS, v);
    n_checks++; if (v !== 32'd16) begin n_fail++; $display("FAIL rows_clamp: got %0d expected 16", v); end
    bus_write(NPU_PARA_Start + P_WCOLS, 32'd17);
    bus_read(NPU_PARA_Start + P_WCOLS, v);
    n_checks++; if (v !== 32'd16) begin n_fail++; $display("FAIL cols_clamp: got %0d expected 16", v); end
    bus_write(NPU_PARA_Start + P_KLAST, 32'd5);
    bus_read(NPU_PARA_Start + P_KLAST, v);
    n_checks++; if (v !== 32'd5) begin n_fail++; $display("FAIL klast_rw: got %0d expected 5", v); end
    bus_write(NPU_PARA_Start + P_STATUS, 32'h0);
    bus_write(NPU_PARA_Start + P_WCOLS, 32'd0);
    bus_write(NPU_OP_Start, 32'h1);
    bus_read(NPU_PARA_Start + P_STATUS, v);
    n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL zero_cols_done: got %h expected 1", v); end
    n_checks++; if (debug2_o !== 32'd0) begin n_fail++; $display("FAIL zero_cols_busy: got %0d expected 0", debug2_o); end
    n_checks++; if (debug3_o !== 4'd0) begin n_fail++; $display("FAIL zero_cols_state: got %0d expected 0", debug3_o); end
  endtask

  task automatic test_gemm;
    bit ok;
    bus_write(NPU_IMEM_Start + 32'd64, 32'd2);
    bus_write(NPU_WMEM_Start + 32'd8,  32'd2);
    bus_write(NPU_BMEM_Start + 32'd12, 32'd0);
    set_params(12, 12, 15);
    bus_write(NPU_OP_Start, 32'h1);
    wait_done(12 * 12 * 17 + 4, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL gemm_done: got %0b expected 1", ok); end
    n_checks++; if (debug2_o !== 32'd2448) begin n_fail++; $display("FAIL gemm_busy_cycles: got %0d expected 2448", debug2_o); end
    n_checks++; if (debug3_o !== 4'd0) begin n_fail++; $display("FAIL gemm_idle: got %0d expected 0", debug3_o); end
  endtask

  task automatic test_transfer(input logic [31:0] exp_max);
    bit ok;
    logic [31:0] v;
    bus_write(NPU_OP_Start + 32'd4, 32'h1);
    wait_done(260, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL xfer_done: got %0b expected 1", ok); end
    n_checks++; if (debug2_o !== 32'd256) begin n_fail++; $display("FAIL xfer_busy_cycles: got %0d expected 256", debug2_o); end
    bus_read(NPU_OMEM_Start, v);
    n_checks++; if (v !== exp_max) begin n_fail++; $display("FAIL xfer_max: got %h expected %h", v, exp_max); end
    bus_read(NPU_OMEM_Start + 32'd72, v);
    n_checks++; if (v !== 32'h4) begin n_fail++; $display("FAIL act_r1c2: got %h expected 4", v); end
    bus_read(NPU_OMEM_Start + 32'd76, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL act_r1c3: got %h expected 0", v); end
  endtask

  task automatic test_start_busy;
    bit ok;
    logic [31:0] d0;
    bus_write(NPU_OP_Start, 32'h1);
    repeat (100) @(posedge clk_i);
    #1 d0 = debug2_o;
    bus_write(NPU_OP_Start, 32'h1);
    n_checks++; if (debug2_o !== d0 + 32'd1) begin n_fail++; $display("FAIL busy_start_cnt: got %0d expected %0d", debug2_o, d0 + 32'd1); end
    wait_done(12 * 12 * 17 + 4, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL busy_gemm_done: got %0b expected 1", ok); end
    n_checks++; if (debug2_o !== 32'd2448) begin n_fail++; $display("FAIL busy_gemm_cycles: got %0d expected 2448", debug2_o); end
    test_transfer(32'h4);
  endtask

  task automatic test_saturation;
    bit ok;
    logic [31:0] v;
    bus_write(NPU_IMEM_Start + 32'd64,  32'd20);
    bus_write(NPU_IMEM_Start + 32'd128, 32'hFFFF_FFEC);
    bus_write(NPU_WMEM_Start, 32'd15);
    set_params(3, 1, 0);
    bus_write(NPU_OP_Start, 32'h1);
    wait_done(10, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sat_gemm_done: got %0b expected 1", ok); end
    n_checks++; if (debug2_o !== 32'd6) begin n_fail++; $display("FAIL sat_gemm_cycles: got %0d expected 6", debug2_o); end
    test_transfer(32'h7F);
    bus_read(NPU_OMEM_Start + 32'h40, v);
    n_checks++; if (v !== 32'h7F) begin n_fail++; $display("FAIL sat_pos: got %h expected 7f", v); end
    bus_read(NPU_OMEM_Start + 32'h80, v);
    n_checks++; if (v !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL sat_neg: got %h expected ffffff80", v); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [31:0] v;
    bus_write(NPU_IMEM_Start + 32'd64,  32'd2);
    bus_write(NPU_IMEM_Start + 32'd128, 32'd0);
    bus_write(NPU_WMEM_Start, 32'd0);
    set_params(12, 12, 15);
    bus_write(NPU_OP_Start, 32'h1);
    repeat (200) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b0;
    #1;
    n_checks++; if (debug3_o !== 4'd0) begin n_fail++; $display("FAIL midrst_state: got %0d expected 0", debug3_o); end
    n_checks++; if (debug2_o !== 32'd0) begin n_fail++; $display("FAIL midrst_busy: got %0d expected 0", debug2_o); end
    n_checks++; if (debug1_o !== 32'd0) begin n_fail++; $display("FAIL midrst_acc: got %0d expected 0", debug1_o); end
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    bus_read(NPU_PARA_Start + P_STATUS, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL midrst_status: got %h expected 0", v); end
    bus_read(NPU_PARA_Start + P_AROWS, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL midrst_rows: got %h expected 0", v); end
    set_params(12, 12, 15);
    bus_write(NPU_OP_Start, 32'h1);
    wait_done(12 * 12 * 17 + 4, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midrst_gemm_done: got %0b expected 1", ok); end
    test_transfer(32'h4);
  endtask

  initial begin
    test_reset();
    init_buffers();
    test_params();
    test_gemm();
    test_transfer(32'h4);
    test_start_busy();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
